// File: rtl/alu_pkg.sv
// Shared constants, opcode/state enums and the command payload for the ALU arbiter.
package alu_pkg;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned FLAG_W = 5;
  localparam int unsigned SH_W   = 4;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned PROD_W = 2 * WIDTH;

  // Bit positions inside the {err, v, c, n, z} flag vector
  localparam int unsigned FLG_Z   = 0;
  localparam int unsigned FLG_N   = 1;
  localparam int unsigned FLG_C   = 2;
  localparam int unsigned FLG_V   = 3;
  localparam int unsigned FLG_ERR = 4;

  typedef enum logic [OP_W-1:0] {
    OP_AND = 4'd0,
    OP_OR  = 4'd1,
    OP_XOR = 4'd2,
    OP_NOT = 4'd3,
    OP_ADD = 4'd4,
    OP_SUB = 4'd5,
    OP_SHL = 4'd6,
    OP_SHR = 4'd7,
    OP_MUL = 4'd8
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } alu_cmd_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: (op, a, b) -> (result, {err, v, c, n, z}).
// Covers opcodes 0-7; everything else, including MUL, reports err.
module alu_core
  import alu_pkg::*;
(
  input  logic [OP_W-1:0]   op_i,
  input  logic [WIDTH-1:0]  a_i,
  input  logic [WIDTH-1:0]  b_i,
  output logic [WIDTH-1:0]  result_o,
  output logic [FLAG_W-1:0] flags_o
);

  logic [WIDTH:0]   sum_w;
  logic [WIDTH:0]   shl_w;
  logic [WIDTH:0]   shr_w;
  logic [WIDTH-1:0] res;
  logic             c;
  logic             v;
  logic             err;

  // Extra guard bit captures carry-out and the last bit shifted out
  assign sum_w = {1'b0, a_i} + {1'b0, b_i};
  assign shl_w = {1'b0, a_i} << b_i[SH_W-1:0];
  assign shr_w = {a_i, 1'b0} >> b_i[SH_W-1:0];

  always_comb begin
    res = '0;
    c   = 1'b0;
    v   = 1'b0;
    err = 1'b0;
    case (op_i)
      OP_AND: res = a_i & b_i;
      OP_OR:  res = a_i | b_i;
      OP_XOR: res = a_i ^ b_i;
      OP_NOT: res = ~a_i;
      OP_ADD: begin
        {c, res} = sum_w;
        v = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (res[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_SUB: begin
        res = a_i - b_i;
        c   = (a_i < b_i);
        v   = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (res[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_SHL: {c, res} = shl_w;
      OP_SHR: {res, c} = shr_w;
      default: err = 1'b1;
    endcase
  end

  assign result_o          = res;
  assign flags_o[FLG_ERR]  = err;
  assign flags_o[FLG_V]    = v;
  assign flags_o[FLG_C]    = c;
  assign flags_o[FLG_N]    = res[WIDTH-1];
  assign flags_o[FLG_Z]    = !err && (res == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end sequencing a shared alu_core.
// Build option: define ALU_MUL_EN to add the 16-cycle shift-add multiply (opcode 8).
module alu_arbiter
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [WIDTH-1:0]  req0_a,
  input  logic [WIDTH-1:0]  req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [WIDTH-1:0]  req1_a,
  input  logic [WIDTH-1:0]  req1_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [WIDTH-1:0]  rsp_data,
  output logic [FLAG_W-1:0] rsp_flags,
  output logic              busy
);

  state_e              state_q, state_d;
  logic                rr_q, rr_d;
  alu_cmd_t            cmd_q, cmd_d;
  logic                id_q, id_d;
  logic [WIDTH-1:0]    data_q, data_d;
  logic [FLAG_W-1:0]   flags_q, flags_d;
  logic                valid_q, busy_q;

  logic                grant_c;
  logic                any_valid_c;
  logic                idle_c;
  logic [WIDTH-1:0]    core_res;
  logic [FLAG_W-1:0]   core_flags;

  // Round-robin pointer only matters when both requesters are valid
  assign any_valid_c = req0_valid || req1_valid;
  assign grant_c     = (req0_valid && req1_valid) ? rr_q : req1_valid;
  assign idle_c      = rst_n && (state_q == ST_IDLE);
  assign req0_ready  = idle_c && req0_valid && !grant_c;
  assign req1_ready  = idle_c && req1_valid && grant_c;

  alu_core u_core (
    .op_i     (cmd_q.op),
    .a_i      (cmd_q.a),
    .b_i      (cmd_q.b),
    .result_o (core_res),
    .flags_o  (core_flags)
  );

`ifdef ALU_MUL_EN
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PROD_W-1:0] prod_q, prod_d;
  logic [PROD_W-1:0] addend_c;
  logic              is_mul_c;

  assign is_mul_c = (cmd_q.op == OP_W'(OP_MUL));
  // Counter doubles as the multiplier bit index for this iteration
  assign addend_c = cmd_q.b[cnt_q] ? (PROD_W'(cmd_q.a) << cnt_q) : '0;
`endif

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    cmd_d   = cmd_q;
    id_d    = id_q;
    data_d  = data_q;
    flags_d = flags_q;
`ifdef ALU_MUL_EN
    cnt_d   = cnt_q;
    prod_d  = prod_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (any_valid_c) begin
          cmd_d   = grant_c ? '{op: req1_op, a: req1_a, b: req1_b}
                            : '{op: req0_op, a: req0_a, b: req0_b};
          id_d    = grant_c;
          rr_d    = !grant_c;
          state_d = ST_EXEC;
`ifdef ALU_MUL_EN
          cnt_d   = CNT_W'(15);
          prod_d  = '0;
`endif
        end
      end
      ST_EXEC: begin
`ifdef ALU_MUL_EN
        if (is_mul_c) begin
          prod_d = prod_q + addend_c;
          cnt_d  = cnt_q - CNT_W'(1);
          if (cnt_q == '0) begin
            data_d         = prod_d[WIDTH-1:0];
            flags_d        = '0;
            flags_d[FLG_C] = |prod_d[PROD_W-1:WIDTH];
            flags_d[FLG_N] = prod_d[WIDTH-1];
            flags_d[FLG_Z] = (prod_d[WIDTH-1:0] == '0);
            state_d        = ST_RESP;
          end
        end else begin
          data_d  = core_res;
          flags_d = core_flags;
          state_d = ST_RESP;
        end
`else
        data_d  = core_res;
        flags_d = core_flags;
        state_d = ST_RESP;
`endif
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rr_q    <= 1'b0;
      cmd_q   <= '0;
      id_q    <= 1'b0;
      data_q  <= '0;
      flags_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef ALU_MUL_EN
      cnt_q   <= '0;
      prod_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      cmd_q   <= cmd_d;
      id_q    <= id_d;
      data_q  <= data_d;
      flags_q <= flags_d;
      valid_q <= (state_d == ST_RESP);
      busy_q  <= (state_d != ST_IDLE);
`ifdef ALU_MUL_EN
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
`endif
    end
  end

  assign rsp_valid = valid_q;
  assign rsp_id    = id_q;
  assign rsp_data  = data_q;
  assign rsp_flags = flags_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed, table-driven bench for alu_arbiter with hand-computed expectations.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [3:0]  req0_op, req1_op;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_id, busy;
  logic [15:0] rsp_data;
  logic [4:0]  rsp_flags;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_flags  (rsp_flags),
    .busy       (busy)
  );

  typedef struct {
    bit          id;
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_data;
    logic [4:0]  exp_flags;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit id, input logic v, input logic [3:0] op,
                       input logic [15:0] a, input logic [15:0] b);
    if (id) begin
      req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
    end else begin
      req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Called at posedge+1 with the request driven; returns at posedge+2 of the accept cycle
  task automatic wait_ready(input bit id, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      if (id ? req1_ready : req0_ready) ok = 1'b1;
      else tick();
    end
  endtask

  // Counts rising edges from the accept edge until rsp_valid is seen
  task automatic wait_rsp(output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!rsp_valid && lat < 40);
  endtask

  task automatic run_op(input vec_t v, input string tag);
    bit ok;
    int lat;
    rsp_ready = 1'b1;
    drive(v.id, 1'b1, v.op, v.a, v.b);
    wait_ready(v.id, ok);
    chk({tag, " ready"}, 32'(ok), 32'd1);
    wait_rsp(lat);
    drive(v.id, 1'b0, 4'd0, 16'd0, 16'd0);
    chk({tag, " data"}, 32'(rsp_data), 32'(v.exp_data));
    chk({tag, " flags"}, 32'(rsp_flags), 32'(v.exp_flags));
    chk({tag, " id"}, 32'(rsp_id), 32'(v.id));
    chk({tag, " latency"}, 32'(lat), 32'(v.exp_lat));
    tick();
    chk({tag, " idle after handshake"}, 32'(busy), 32'd0);
  endtask

  task automatic add_vec(input bit id, input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] d, input logic [4:0] f,
                         input int lat);
    vec_t v;
    v = '{id: id, op: op, a: a, b: b, exp_data: d, exp_flags: f, exp_lat: lat};
    vecs.push_back(v);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    rst_n = 1'b0;
    rsp_ready = 1'b0;
    drive(1'b0, 1'b0, 4'd0, 16'd0, 16'd0);
    drive(1'b1, 1'b0, 4'd0, 16'd0, 16'd0);

    // flags are {err, v, c, n, z}
    add_vec(0, 4'd2, 16'h000E, 16'h0015, 16'h001B, 5'b00000, 2);
    add_vec(0, 4'd0, 16'hF0F0, 16'h0FF0, 16'h00F0, 5'b00000, 2);
    add_vec(1, 4'd1, 16'h0000, 16'h0000, 16'h0000, 5'b00001, 2);
    add_vec(1, 4'd3, 16'h00FF, 16'h1234, 16'hFF00, 5'b00010, 2);
    add_vec(0, 4'd4, 16'hFFFF, 16'h0001, 16'h0000, 5'b00101, 2);
    add_vec(0, 4'd4, 16'h8000, 16'h8000, 16'h0000, 5'b01101, 2);
    add_vec(1, 4'd5, 16'h0005, 16'h0005, 16'h0000, 5'b00001, 2);
    add_vec(0, 4'd5, 16'h8000, 16'h0001, 16'h7FFF, 5'b01000, 2);
    add_vec(0, 4'd6, 16'h8001, 16'h0001, 16'h0002, 5'b00100, 2);
    add_vec(1, 4'd6, 16'h1234, 16'h0000, 16'h1234, 5'b00000, 2);
    add_vec(0, 4'd7, 16'h0003, 16'h0002, 16'h0000, 5'b00101, 2);
    add_vec(0, 4'd7, 16'h8000, 16'hFFFF, 16'h0001, 5'b00000, 2);
    add_vec(1, 4'd9, 16'h1234, 16'h5678, 16'h0000, 5'b10000, 2);
    add_vec(0, 4'd15, 16'hFFFF, 16'hFFFF, 16'h0000, 5'b10000, 2);
`ifdef ALU_MUL_EN
    add_vec(0, 4'd8, 16'h0100, 16'h0100, 16'h0000, 5'b00101, 17);
    add_vec(1, 4'd8, 16'h0003, 16'h0005, 16'h000F, 5'b00000, 17);
    add_vec(0, 4'd8, 16'hFFFF, 16'hFFFF, 16'h0001, 5'b00100, 17);
`else
    add_vec(0, 4'd8, 16'h0100, 16'h0100, 16'h0000, 5'b10000, 2);
`endif

    // Reset state, including readies held low while reset is asserted
    tick();
    tick();
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset req0_ready", 32'(req0_ready), 32'd0);
    chk("reset req1_ready", 32'(req1_ready), 32'd0);
    chk("reset rsp_data", 32'(rsp_data), 32'd0);
    chk("reset rsp_flags", 32'(rsp_flags), 32'd0);
    req0_valid = 1'b1;
    #1;
    chk("req0_ready during reset", 32'(req0_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("req0_ready idle", 32'(req0_ready), 32'd1);
    req0_valid = 1'b0;
    tick();

    foreach (vecs[i]) run_op(vecs[i], $sformatf("vec%0d", i));

    // Both valid from reset: req0 first, response held for 5 cycles
    do_reset();
    rsp_ready = 1'b0;
    drive(0, 1'b1, 4'd4, 16'h7FFF, 16'h0001);
    drive(1, 1'b1, 4'd5, 16'h0003, 16'h0005);
    #1;
    chk("both req0_ready", 32'(req0_ready), 32'd1);
    chk("both req1_ready", 32'(req1_ready), 32'd0);
    tick();
    drive(0, 1'b0, 4'd0, 16'd0, 16'd0);
    tick();
    chk("add rsp_valid", 32'(rsp_valid), 32'd1);
    chk("add data", 32'(rsp_data), 32'h8000);
    chk("add flags", 32'(rsp_flags), 32'b01010);
    chk("add id", 32'(rsp_id), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("hold%0d valid", i), 32'(rsp_valid), 32'd1);
      chk($sformatf("hold%0d data", i), {11'd0, rsp_flags, rsp_data}, {11'd0, 5'b01010, 16'h8000});
      chk($sformatf("hold%0d id", i), 32'(rsp_id), 32'd0);
      chk($sformatf("hold%0d readies", i), {30'd0, req0_ready, req1_ready}, 32'd0);
      chk($sformatf("hold%0d busy", i), 32'(busy), 32'd1);
    end
    rsp_ready = 1'b1;
    tick();
    chk("release busy", 32'(busy), 32'd0);
    chk("release rsp_valid", 32'(rsp_valid), 32'd0);
    chk("release req1_ready", 32'(req1_ready), 32'd1);
    tick();
    drive(1, 1'b0, 4'd0, 16'd0, 16'd0);
    tick();
    chk("sub rsp_valid", 32'(rsp_valid), 32'd1);
    chk("sub data", 32'(rsp_data), 32'hFFFE);
    chk("sub flags", 32'(rsp_flags), 32'b00110);
    chk("sub id", 32'(rsp_id), 32'd1);
    tick();

    // Continuous contention alternates grants 0,1,0,1
    drive(0, 1'b1, 4'd1, 16'h1111, 16'h0000);
    drive(1, 1'b1, 4'd1, 16'h2222, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      wait_rsp(lat);
      chk($sformatf("alt%0d id", i), 32'(rsp_id), 32'(i % 2));
      chk($sformatf("alt%0d data", i), 32'(rsp_data), (i % 2 == 1) ? 32'h2222 : 32'h1111);
      if (i == 3) begin
        drive(0, 1'b0, 4'd0, 16'd0, 16'd0);
        drive(1, 1'b0, 4'd0, 16'd0, 16'd0);
      end
    end
    tick();

    // Reset in the middle of an op; pointer must return to req0
    drive(0, 1'b1, 4'd8, 16'h0003, 16'h0005);
    #1;
    chk("mid-op req0_ready", 32'(req0_ready), 32'd1);
    tick();
    drive(0, 1'b0, 4'd0, 16'd0, 16'd0);
`ifdef ALU_MUL_EN
    repeat (7) tick();
    chk("mul in flight busy", 32'(busy), 32'd1);
`endif
    rst_n = 1'b0;
    #1;
    chk("mid reset busy", 32'(busy), 32'd0);
    chk("mid reset rsp_valid", 32'(rsp_valid), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    drive(0, 1'b1, 4'd0, 16'hFFFF, 16'h00FF);
    drive(1, 1'b1, 4'd2, 16'h00FF, 16'h00FF);
    #1;
    chk("post reset req0_ready", 32'(req0_ready), 32'd1);
    chk("post reset req1_ready", 32'(req1_ready), 32'd0);
    wait_rsp(lat);
    drive(0, 1'b0, 4'd0, 16'd0, 16'd0);
    drive(1, 1'b0, 4'd0, 16'd0, 16'd0);
    chk("post reset id", 32'(rsp_id), 32'd0);
    chk("post reset data", 32'(rsp_data), 32'h00FF);
    chk("post reset latency", 32'(lat), 32'd2);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester front end for the 16-bit ALU: arbitrates round-robin between two operation requesters, latches the winning operands, sequences execution on a single shared `alu_core` datapath, and returns a registered result with status flags over a valid/ready response channel. It sits between the processor's issue logic (and a second client such as an address/DMA unit) and the combinational ALU, so no requester drives ALU operands directly.

## Interface
- `WIDTH`, 16, operand/result width
- `OP_W`, 4, opcode width
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `req0_valid` in 1 / `req0_ready` out 1 / `req0_op` in OP_W / `req0_a` in WIDTH / `req0_b` in WIDTH: requester 0 command
- `req1_valid` in 1 / `req1_ready` out 1 / `req1_op` in OP_W / `req1_a` in WIDTH / `req1_b` in WIDTH: requester 1 command
- `rsp_valid` out 1: result available
- `rsp_ready` in 1: consumer accepts result
- `rsp_id` out 1: requester that issued the op
- `rsp_data` out WIDTH: result
- `rsp_flags` out 5: {err, v, c, n, z}
- `busy` out 1: state != IDLE

## Operation
- Opcodes: 0 AND, 1 OR, 2 XOR, 3 NOT a, 4 ADD, 5 SUB (a-b), 6 SHL a by b[3:0], 7 SHR logical a by b[3:0], 8 MUL (macro-dependent), 9-15 illegal.
- FSM states IDLE, EXEC, RESP. Reset -> IDLE, rr pointer = 0, all outputs 0.
- IDLE: grant = only valid requester, or the rr-pointer one if both valid. `reqK_ready` = (IDLE && grant==K), combinational from valids; requesters must not make valid depend on ready. On accept: latch op/a/b/id, pointer <= ~id, go to EXEC.
- EXEC: single-cycle ops register result/flags, go to RESP. MUL runs shift-add for 16 cycles (4-bit counter 15->0), then RESP.
- RESP: `rsp_valid`=1, data/id/flags stable until `rsp_ready`; on handshake go to IDLE. No accept is possible in RESP or EXEC.
- Flags: z = result==0; n = result[15]. ADD: c = carry-out, v = signed overflow. SUB: c = borrow (a<b unsigned), v = signed overflow. SHL/SHR: c = last bit shifted out, 0 for amount 0. MUL: result = low 16 bits of product, c = high 16 bits nonzero, v=0. Logic ops: c=v=0.
- Illegal opcode: data 0, err=1, other flags 0, single-cycle latency.

## Timing
- Accept on edge N -> EXEC cycle N+1 -> `rsp_valid` high from N+2 (MUL: from N+17).
- Max throughput one op per 3 cycles (response accepted immediately).
- Both requesters valid continuously: grants alternate 0,1,0,1...
- Unaccepted requests must be held stable by the requester.
- Reset asserted in any state: immediate return to IDLE, in-flight op discarded, `rsp_valid`/`busy`/readies 0, pointer 0.

## Configuration
- `ALU_MUL_EN` defined: opcode 8 executes the 16-cycle iterative multiply, with the counter and partial-product register present.
- Undefined: opcode 8 is illegal (err=1, data 0, 2-cycle latency); no multiply hardware is built.

## Structure
- `alu_pkg`: WIDTH/OP_W constants, opcode enum, flag bit indices, FSM state enum.
- Sub-module `alu_core`: purely combinational, (op, a, b) -> (result, flags), covering opcodes 0-7 and illegal. Multiply iteration stays in `alu_arbiter`.

## Test plan
- Reset with both valids low -> `rsp_valid`=0, `busy`=0, both readies 0. Then req0_valid with idle FSM -> `req0_ready`=1.
- req0 XOR a=0x000E b=0x0015 -> rsp_data 0x001B, rsp_id 0, flags 0, `rsp_valid` exactly 2 cycles after accept.
- Both valid from reset with ADD 0x7FFF+0x0001 (req0) and SUB 0x0003-0x0005 (req1) -> req0 served first: 0x8000 with n=1, v=1, c=0; then req1: 0xFFFE with n=1, c=1.
- Hold `rsp_ready` low 5 cycles -> rsp_data/id/flags stable, both readies 0, `busy`=1. Release -> IDLE next cycle.
- With `ALU_MUL_EN`: MUL 0x0100*0x0100 -> data 0x0000, z=1, c=1, `rsp_valid` 17 cycles after accept. Without it -> err=1, data 0, latency 2.
- Assert `rst_n` low at EXEC cycle 8 of a MUL -> `busy`/`rsp_valid` drop immediately; after release the next request is served normally with req0 priority.
